// File: rtl/ysyx_25030093_lsu_sram.sv
// Memory-side responder for the LSU request/response interface.
// Accepts one request at a time, holds it for a programmable latency
// (optionally stretched by an LFSR), then commits a byte-masked write or
// returns the full aligned word with a one-cycle response pulse.
module ysyx_25030093_lsu_sram #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 2,
  parameter int          RAND_DELAY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_respErr,
  output logic        req_ready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [31:0] SPAN   = 32'(DEPTH * 4);
  localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          commit;
  logic [4:0]    cnt;
  logic [4:0]    cnt_load;
  logic [7:0]    lfsr;
  logic [31:0]   addr_q;
  logic [1:0]    size_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic [31:0]   offset;
  logic          range_err;
  logic          align_err;
  logic          acc_err;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  // Byte-lane merge of new write data into an existing word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Offset wraps to a huge value below BASE, so one unsigned compare covers both ends.
  assign offset    = addr_q - BASE;
  assign range_err = (offset >= SPAN);
  assign align_err = (size_q == 2'b10) && (addr_q[1:0] != 2'b00);
  assign acc_err   = range_err || align_err;
  assign idx       = offset[AW+1:2];

  assign cnt_load  = LAT_M1 + ((RAND_DELAY != 0) ? {2'b00, lfsr[2:0]} : 5'd0);
  assign req_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus accept/commit strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu_reqValid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 5'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency countdown: loaded on accept, decremented while waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 5'd0;
    end else if (accept) begin
      cnt <= cnt_load;
    end else if (state == WAIT && cnt != 5'd0) begin
      cnt <= cnt - 5'd1;
    end
  end

  // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Request capture on accept; data fields carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= lsu_addr;
      size_q  <= lsu_size;
      wen_q   <= lsu_wen;
      wdata_q <= lsu_wdata;
      wmask_q <= lsu_wmask;
    end
  end

  // Registered response: pulse and payload produced on the commit edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      lsu_respValid <= 1'b0;
      lsu_rdata     <= 32'h0;
      lsu_respErr   <= 1'b0;
    end else begin
      lsu_respValid <= commit;
      if (commit) begin
        lsu_respErr <= acc_err;
        lsu_rdata   <= (acc_err || wen_q) ? 32'h0 : mem[idx];
      end
    end
  end

  // Memory write on the commit edge; a reset on that edge discards it.
  always_ff @(posedge clock) begin
    if (commit && !reset && !acc_err && wen_q) begin
      mem[idx] <= merge_lanes(mem[idx], wdata_q, wmask_q);
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_lsu_sram.sv
// Self-checking bench for ysyx_25030093_lsu_sram: a fixed-latency instance
// and a random-delay instance share the request inputs; a word-level model
// predicts every response.
module tb_ysyx_25030093_lsu_sram;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rv0, err0, rdy0, rv1, err1, rdy1;
  logic [31:0] rd0, rd1;

  ysyx_25030093_lsu_sram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT), .RAND_DELAY(0)) dut0 (
    .clock(clock), .reset(reset), .lsu_reqValid(req_valid), .lsu_addr(addr),
    .lsu_size(size), .lsu_wen(wen), .lsu_wdata(wdata), .lsu_wmask(wmask),
    .lsu_respValid(rv0), .lsu_rdata(rd0), .lsu_respErr(err0), .req_ready(rdy0));

  ysyx_25030093_lsu_sram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT), .RAND_DELAY(1)) dut1 (
    .clock(clock), .reset(reset), .lsu_reqValid(req_valid), .lsu_addr(addr),
    .lsu_size(size), .lsu_wen(wen), .lsu_wdata(wdata), .lsu_wmask(wmask),
    .lsu_respValid(rv1), .lsu_rdata(rd1), .lsu_respErr(err1), .req_ready(rdy1));

  always #5 clock = ~clock;

  typedef struct {
    int          t;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [int];
  int          cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  bit          chk_en = 1'b0;
  bit          sel = 1'b0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Every-cycle comparison of the selected DUT against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      logic        rv, er, rdy;
      logic [31:0] rd;
      exp_t        e;
      rv  = sel ? rv1 : rv0;
      er  = sel ? err1 : err0;
      rd  = sel ? rd1 : rd0;
      rdy = sel ? rdy1 : rdy0;
      if (!sel) begin
        chk("respValid", 32'(rv), 32'((q.size() > 0) && (cyc == q[0].t + LAT + 1)));
        chk("req_ready", 32'(rdy), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
      end
      if (rv) begin
        if (q.size() == 0) begin
          if (sel) chk("spurious_resp", 32'(rv), 32'h0);
        end else begin
          e = q.pop_front();
          chk("rdata", rd, e.rdata);
          chk("respErr", 32'(er), 32'(e.err));
          if (sel) chk("latency_window", 32'((cyc - e.t >= LAT + 1) && (cyc - e.t <= LAT + 8)), 32'h1);
          last_rdata = rd;
          last_err   = er;
          last_cyc   = cyc;
        end
      end
    end
  end

  // One-cycle request pulse; when push is set the model predicts its response.
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic w,
                       input logic [31:0] d, input logic [3:0] m, input bit push,
                       output int t);
    exp_t        e;
    logic        bad;
    int          wi;
    logic [31:0] word;
    @(posedge clock); #1;
    req_valid = 1'b1; addr = a; size = s; wen = w; wdata = d; wmask = m;
    t = cyc;
    if (push) begin
      bad = (a < BASE) || (a > BASE + DEPTH * 4 - 1) || (s == 2'b10 && a[1:0] != 2'b00);
      wi  = int'((a - BASE) >> 2);
      e.t = t;
      e.err = bad;
      e.rdata = 32'h0;
      if (!bad && w) begin
        word = mdl.exists(wi) ? mdl[wi] : 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) word[8*i +: 8] = d[8*i +: 8];
        mdl[wi] = word;
      end else if (!bad) begin
        e.rdata = mdl.exists(wi) ? mdl[wi] : 32'h0;
      end
      q.push_back(e);
      busy_lo = t + 1;
      busy_hi = t + LAT + 1;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    if (q.size() > 0) begin
      nchk++;
      nerr++;
      $display("FAIL resp_timeout: %0d responses still pending after %0d cycles", q.size(), n);
      q.delete();
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [1:0] s, input logic w,
                     input logic [31:0] d, input logic [3:0] m, output int t);
    issue(a, s, w, d, m, 1'b1, t);
    wait_resp();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    busy_lo = 1;
    busy_hi = 0;
  endtask

  initial begin
    int          t, t2;
    int          ri;
    logic [1:0]  rs;
    logic [31:0] ra;
    req_valid = 1'b0; addr = 32'h0; size = 2'b10; wen = 1'b0; wdata = 32'h0; wmask = 4'h0;

    // Fixed-latency instance
    do_reset();
    chk("reset_respValid", 32'(rv0), 32'h0);
    chk("reset_rdata", rd0, 32'h0);
    chk("reset_respErr", 32'(err0), 32'h0);
    chk("reset_req_ready", 32'(rdy0), 32'h1);
    chk_en = 1'b1;

    txn(32'h8000_0010, 2'b10, 1'b1, 32'hDEADBEEF, 4'hF, t);
    chk("write_latency", 32'(last_cyc - t), 32'd3);
    chk("write_err", 32'(last_err), 32'h0);
    txn(32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("read_deadbeef", last_rdata, 32'hDEADBEEF);

    txn(32'h8000_0010, 2'b10, 1'b1, 32'h1122_3344, 4'hF, t);
    txn(32'h8000_0012, 2'b00, 1'b1, 32'h00AB_0000, 4'b0100, t);
    chk("byte_write_rdata_zero", last_rdata, 32'h0);
    txn(32'h8000_0013, 2'b00, 1'b0, 32'h0, 4'h0, t);
    chk("byte_merge", last_rdata, 32'h11AB_3344);

    txn(32'h1000_0000, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("oor_read_err", 32'(last_err), 32'h1);
    chk("oor_read_data", last_rdata, 32'h0);
    txn(32'h8000_0002, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("misaligned_word_err", 32'(last_err), 32'h1);
    txn(32'h1000_0010, 2'b10, 1'b1, 32'hFFFF_FFFF, 4'hF, t);
    chk("oor_write_err", 32'(last_err), 32'h1);
    txn(32'h8000_0011, 2'b10, 1'b1, 32'hFFFF_FFFF, 4'hF, t);
    txn(32'h8000_0010, 2'b10, 1'b1, 32'hFFFF_FFFF, 4'h0, t);
    txn(32'h8000_0010, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("mem_unchanged", last_rdata, 32'h11AB_3344);

    txn(32'h8000_0FFC, 2'b10, 1'b1, 32'hCAFE_F00D, 4'hF, t);
    txn(32'h8000_0FFC, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("top_word", last_rdata, 32'hCAFE_F00D);
    txn(32'h8000_1000, 2'b00, 1'b0, 32'h0, 4'h0, t);
    chk("past_top_err", 32'(last_err), 32'h1);
    txn(32'h7FFF_FFFC, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("below_base_err", 32'(last_err), 32'h1);

    // Second pulse during WAIT is dropped
    issue(32'h8000_0020, 2'b10, 1'b1, 32'hAAAA_AAAA, 4'hF, 1'b1, t);
    issue(32'h8000_0020, 2'b10, 1'b1, 32'h5555_5555, 4'hF, 1'b0, t2);
    wait_resp();
    repeat (4) @(posedge clock);
    txn(32'h8000_0020, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("drop_in_wait", last_rdata, 32'hAAAA_AAAA);

    // Reset during WAIT of a write
    issue(32'h8000_0020, 2'b10, 1'b1, 32'h1234_5678, 4'hF, 1'b0, t);
    busy_lo = t + 1;
    busy_hi = t + 1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("ready_after_reset", 32'(rdy0), 32'h1);
    chk("no_resp_after_reset", 32'(rv0), 32'h0);
    repeat (6) @(posedge clock);
    txn(32'h8000_0020, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("reset_discards_write", last_rdata, 32'hAAAA_AAAA);

    // Reset and request on the same edge
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 1'b1; addr = 32'h8000_0020; wen = 1'b1; wdata = 32'h0; wmask = 4'hF;
    @(posedge clock); #1;
    reset = 1'b0; req_valid = 1'b0;
    chk("reset_beats_req", 32'(rdy0), 32'h1);
    repeat (6) @(posedge clock);
    txn(32'h8000_0020, 2'b10, 1'b0, 32'h0, 4'h0, t);
    chk("reset_req_no_write", last_rdata, 32'hAAAA_AAAA);

    // Random-delay instance
    do_reset();
    mdl.delete();
    sel = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++)
      txn(32'h8000_0100 + 32'(i * 4), 2'b10, 1'b1, 32'h0101_0101 * 32'(i + 1), 4'hF, t);
    for (int n = 0; n < 200; n++) begin
      ri = $urandom_range(0, 15);
      rs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      ra = 32'h8000_0100 + 32'(ri * 4) + ((rs == 2'b10) ? 32'h0 : 32'($urandom_range(0, 3)));
      txn(ra, rs, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), t);
    end

    repeat (10) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_lsu_sram.md
# ysyx_25030093_lsu_sram

Memory-side responder for the LSU request/response interface. It accepts one single-cycle load/store request, holds it for a programmable latency, then commits byte-masked writes or returns a full aligned word, signalled by a one-cycle response pulse. It sits behind the LSU as the RAM target for the window starting at `BASE`. It serves as both the simulation memory model and the latency/back-pressure stimulus source for LSU verification.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `BASE`, 32'h8000_0000: byte address of word 0; aligned to `DEPTH*4`.
- `LATENCY`, 2: base cycles from accept to commit; legal range 1..15.
- `RAND_DELAY`, 0: when 1, add 0..7 extra cycles per request from an internal LFSR.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `lsu_reqValid` input 1: request strobe, one cycle wide.
- `lsu_addr` input 32: byte address; bits [1:0] are ignored for indexing.
- `lsu_size` input 2: 2'b10 selects word, 2'b00 selects byte; other codes are treated as byte.
- `lsu_wen` input 1: 1 = write, 0 = read.
- `lsu_wdata` input 32: write data, already lane-shifted by the initiator.
- `lsu_wmask` input 4: byte-lane write enables.
- `lsu_respValid` output 1: response pulse, one cycle wide.
- `lsu_rdata` output 32: aligned read word; valid only while `lsu_respValid` is high.
- `lsu_respErr` output 1: error flag; qualified by `lsu_respValid`.
- `req_ready` output 1: high only in IDLE.

## Operation
- States are IDLE, WAIT and RESP.
- IDLE:
  - A request is accepted when `lsu_reqValid` is high at the edge.
  - On accept, the block latches addr, size, wen, wdata and wmask.
  - It loads `cnt = LATENCY-1 + (RAND_DELAY ? lfsr[2:0] : 0)` and moves to WAIT.
- `lsu_reqValid` seen in WAIT or RESP is dropped: no queueing, no side effects. The initiator must wait for the response.
- WAIT:
  - Each edge with `cnt != 0` decrements `cnt`.
  - The edge with `cnt == 0` moves to RESP and performs the access at that same edge.
- Access index is `(addr - BASE) >> 2`.
- Error cases (either one sets the error):
  - The address is outside `[BASE, BASE + DEPTH*4 - 1]`.
  - A word access (`lsu_size == 2'b10`) has `addr[1:0] != 0`.
- Error handling: no memory update, `lsu_rdata` is 32'h0 and `lsu_respErr` is 1.
- Write: for each lane i with `wmask[i]` set, `mem[idx][8i+7:8i] <= wdata[8i+7:8i]`.
  - `wmask == 0` changes nothing but still responds normally.
  - `lsu_rdata` returns 32'h0 on a write response.
- Read: `lsu_rdata <= mem[idx]`, the full word, regardless of size or mask. Byte extraction is done by the LSU.
- RESP: `lsu_respValid` is high for exactly one cycle, then the block returns to IDLE unconditionally.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Seeded to 8'hA5 on reset.
  - Advances every cycle regardless of state.
- Memory array is not cleared by reset.

## Timing
- Reset values:
  - `lsu_respValid` = 0.
  - `lsu_rdata` = 32'h0.
  - `lsu_respErr` = 0.
  - state = IDLE, so `req_ready` = 1.
  - `cnt` = 0.
  - LFSR = 8'hA5.
- `lsu_respValid`, `lsu_rdata` and `lsu_respErr` are registered. `req_ready` is decoded from state.
- Latency: with `lsu_reqValid` high in cycle T, `lsu_respValid` is high in cycle T+LATENCY+1+extra, where extra = 0 when `RAND_DELAY = 0`.
- A write commits on the edge that enters RESP. A read accepted in any later cycle returns the new data.
- Back-to-back: the earliest next accept is the cycle after RESP. Minimum request spacing is LATENCY+2 cycles.
- A request with `lsu_reqValid` high during the RESP cycle is ignored.
- Reset mid-operation (WAIT or RESP): return to IDLE.
  - Any pending write is discarded if its commit edge has not occurred.
  - `lsu_respValid` is forced low at the next edge, and no late response follows.
- Reset and `lsu_reqValid` at the same edge: reset wins and the request is not accepted.

## Test plan
- LATENCY=2: write 32'hDEADBEEF, wmask 4'hF, to 32'h8000_0010 at cycle T.
  - `lsu_respValid` high only in cycle T+3, with `lsu_respErr` = 0.
  - A following read of 32'h8000_0010 returns 32'hDEADBEEF.
- Byte write to 32'h8000_0012 with wdata 32'h00AB_0000 and wmask 4'b0100 onto word 32'h1122_3344.
  - A read of 32'h8000_0013 (size 2'b00) returns 32'h11AB_3344.
- Read of 32'h1000_0000 (out of range) responds with `lsu_respErr` = 1 and `lsu_rdata` = 0. A word read of 32'h8000_0002 also errors.
  - Memory is unchanged after an out-of-range write.
- Issue a second `lsu_reqValid` pulse during WAIT.
  - It is ignored, and exactly one response arrives.
  - Memory reflects only the first request.
- Assert `reset` during WAIT of a write.
  - No `lsu_respValid` appears, the target word is unchanged and `req_ready` = 1 after the reset edge.
- RAND_DELAY=1: over 200 requests, every response latency lies in [LATENCY+1, LATENCY+8].
  - Each request gets exactly one response, and read data matches a reference model.
